// File: rtl/inv_mixcolumn.sv
// Iterative AES (Inv)MixColumns engine: one 32-bit column per clock,
// valid/ready handshakes on input and output.
// Optional macro INV_MIXCOL_FWD_EN adds an enc_mode port that selects the
// forward MixColumns matrix for the whole state; it is sampled at input accept.
//
// state  | meaning
// IDLE   | waiting for a state on the input handshake
// BUSY   | transforming column cnt_q in place, one column per clock
// DONE   | result held on data_out until out_ready

module inv_mixcolumn (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_MIXCOL_FWD_EN
  input  logic         enc_mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [31:0]  col_cur, col_new;
`ifdef INV_MIXCOL_FWD_EN
  logic         enc_q, enc_d;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // Byte 0 of the column sits in the MSBs.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef INV_MIXCOL_FWD_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m3[i] = m2[i] ^ a[i];
    end
    return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
            a[0]  ^ m2[1] ^ m3[2] ^ a[3],
            a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
            m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
  endfunction
`endif

  // Select the column addressed by the counter; a single transform instance.
  always_comb begin
    col_cur = data_q[127:96];
    case (cnt_q)
      2'd0: col_cur = data_q[127:96];
      2'd1: col_cur = data_q[95:64];
      2'd2: col_cur = data_q[63:32];
      2'd3: col_cur = data_q[31:0];
      default: col_cur = data_q[127:96];
    endcase
`ifdef INV_MIXCOL_FWD_EN
    col_new = enc_q ? fwd_col(col_cur) : inv_col(col_cur);
`else
    col_new = inv_col(col_cur);
`endif
  end

  // Next-state logic: accept, in-place column update, output hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef INV_MIXCOL_FWD_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          cnt_d   = 2'd0;
          state_d = S_BUSY;
`ifdef INV_MIXCOL_FWD_EN
          enc_d   = enc_mode;
`endif
        end
      end
      S_BUSY: begin
        case (cnt_q)
          2'd0: data_d[127:96] = col_new;
          2'd1: data_d[95:64]  = col_new;
          2'd2: data_d[63:32]  = col_new;
          2'd3: data_d[31:0]   = col_new;
          default: data_d = data_q;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
`ifdef INV_MIXCOL_FWD_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef INV_MIXCOL_FWD_EN
      enc_q   <= enc_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_inv_mixcolumn.sv
// Scoreboard bench for inv_mixcolumn; the forward-mode tests are built only
// when INV_MIXCOL_FWD_EN is defined.

module tb_inv_mixcolumn;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         enc_mode;

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  inv_mixcolumn dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef INV_MIXCOL_FWD_EN
    .enc_mode (enc_mode),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d, input logic enc);
    logic [7:0]   base [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [127:0] res;
    if (enc) begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end else begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = d[127-32*c-8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int k = 0; k < 4; k++) r = r ^ gmul(base[(k - row + 4) % 4], a[k]);
        res[127-32*c-8*row -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic put(input logic [127:0] d, input logic [127:0] exp, input logic enc);
    int n;
    n = 0;
    @(negedge clk);
    data_in  = d;
    enc_mode = enc;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic get(input int stall, output logic [127:0] res);
    int n;
    logic [127:0] held;
    logic [127:0] exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("latency", 128'(n - 1), 128'd4);
    held = data_out;
    repeat (stall) begin
      in_valid = 1'b1;
      data_in  = rnd128();
      @(negedge clk);
      check("stall_data", data_out, held);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 128'(exp_q.size()), 128'd1);
      exp = 'x;
    end else begin
      exp = exp_q.pop_front();
    end
    check("data", data_out, exp);
    res = data_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after", 128'(in_ready), 128'd1);
    check("out_valid_after", 128'(out_valid), 128'd0);
  endtask

  // Continuous in_valid/out_ready: accepts must be exactly 6 cycles apart.
  task automatic stream(input int nvec);
    int acc[$];
    int cyc, sent, recv;
    logic [127:0] d, exp;
    cyc = 0; sent = 0; recv = 0;
    out_ready = 1'b1;
    @(negedge clk);
    d = rnd128();
    data_in  = d;
    enc_mode = 1'b0;
    in_valid = 1'b1;
    while (recv < nvec && cyc < 200) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_state(d, 1'b0));
        acc.push_back(cyc);
        sent++;
      end
      if (out_valid) begin
        exp = exp_q.pop_front();
        check("stream_data", data_out, exp);
        recv++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc.size() == sent && sent > 0 && acc[sent-1] == cyc - 1) begin
        if (sent < nvec) begin
          d = rnd128();
          data_in = d;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("stream_count", 128'(recv), 128'(nvec));
    for (int i = 1; i < acc.size(); i++)
      check("stream_interval", 128'(acc[i] - acc[i-1]), 128'd6);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [127:0] d, r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    enc_mode  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    rst_n = 1'b1;

    // Known vectors
    d = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    put(d, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    get(0, r);
    check("ref_model_v1", ref_state(d, 1'b0), r);
    put(128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff,
        128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0);
    get(0, r);

    // Backpressure
    d = rnd128();
    put(d, ref_state(d, 1'b0), 1'b0);
    get(10, r);

    // Back-to-back throughput
    stream(3);

    // Reset in the middle of BUSY
    d = rnd128();
    put(d, ref_state(d, 1'b0), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_data_out", data_out, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    d = rnd128();
    put(d, ref_state(d, 1'b0), 1'b0);
    get(0, r);

    // Random states
    for (int i = 0; i < 1000; i++) begin
      d = rnd128();
      put(d, ref_state(d, 1'b0), 1'b0);
      get(0, r);
    end

`ifdef INV_MIXCOL_FWD_EN
    put(128'hdb135345_f20a225c_01010101_c6c6c6c6,
        128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1);
    get(0, r);
    for (int i = 0; i < 50; i++) begin
      d = rnd128();
      put(d, ref_state(d, 1'b1), 1'b1);
      get(0, r);
      put(r, d, 1'b0);
      get(0, r);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inv_mixcolumn.md
# inv_mixcolumn

Iterative AES InvMixColumns engine for the decryption datapath: accepts a 128-bit state, multiplies each 32-bit column by the inverse matrix {0e,0b,0d,09} over GF(2^8), and returns the 128-bit result. It processes one column per clock and uses valid/ready handshakes on both sides. It sits after the inverse ShiftRows/SubBytes stages and the AddRoundKey stage in each decryption round, mirroring the forward column mixer on the encryption side.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a state.
- data_in  input  128  state; column 0 = [127:96], column 3 = [31:0], byte 0 of each column in its MSBs.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  128  result, same packing as data_in.
- enc_mode  input  1  present only with INV_MIXCOL_FWD_EN: 1 = forward MixColumns.

## Operation
- Reset is asynchronous on rst_n low and all values are held while rst_n is low.
  - FSM = IDLE; column counter = 0; state register = 0.
  - in_ready = 1, out_valid = 0, data_out = 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1: capture data_in into the state register, clear the counter, go to BUSY.
  - With INV_MIXCOL_FWD_EN, enc_mode is also captured on this edge.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge replaces column[counter] in place with its transformed value, then increments the counter.
  - The edge that processes counter = 3 wraps the counter to 0 and moves to DONE.
- DONE:
  - out_valid = 1; data_out = state register, stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE, so there is no simultaneous accept and emit.
- Column transform for input bytes a0..a3 (output bytes r0..r3):
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3; the other rows rotate the coefficients.
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3.
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3.
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3.
- Arithmetic rules:
  - xtime(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}).
  - 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2, where x2, x4, x8 are successive xtime applications.
  - All arithmetic is combinational within one cycle; only one column's worth of logic is instantiated, muxed by the counter.
- in_valid during BUSY or DONE is ignored; the upstream source holds it until it sees in_ready.
- Reset mid-operation (BUSY or DONE) discards the partial result and returns to the reset values.

## Timing
- Latency: input handshake on edge E0; columns 0–3 are processed on E1–E4; out_valid = 1 after E4.
- Output handshake at earliest on E5; in_ready = 1 after E5; next accept at earliest on E6.
- Maximum throughput: one state per 6 cycles.
- out_ready held low stalls the block in DONE indefinitely with data_out unchanged.
- All outputs are registered or decoded only from FSM state; there are no combinational input-to-output paths.

## Configuration
- INV_MIXCOL_FWD_EN defined:
  - The enc_mode port exists and is sampled at input handshake.
  - enc_mode=1 applies the forward matrix {02,03,01,01} (r0 = 02·a0 ^ 03·a1 ^ a2 ^ a3, rotated); enc_mode=0 applies the inverse matrix.
  - Timing is identical in both modes.
- INV_MIXCOL_FWD_EN undefined:
  - No enc_mode port and no forward logic; inverse-only behaviour.

## Test plan
- Known vector: data_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1 → out_valid 4 cycles after accept; data_out = db135345_f20a225c_01010101_c6c6c6c6.
- Second vector: data_in = d5d5d7d6_4d7ebdf8_... (any remaining two columns) → columns 0/1 = d4d4d4d5_2d26314c; handshake takes exactly 6 cycles between accepts under continuous in_valid/out_ready.
- Backpressure: out_ready=0 for 10 cycles after out_valid → data_out stable, in_ready=0, in_valid ignored; accepted on the first out_ready=1 edge.
- Reset mid-BUSY: drop rst_n after E2 → in_ready=1, out_valid=0, data_out=0 immediately; the next input produces a correct result.
- Random: 1000 random states → compare against a reference model; with INV_MIXCOL_FWD_EN, a forward pass followed by an inverse pass returns the original state.
- With INV_MIXCOL_FWD_EN, enc_mode=1, data_in column db135345 → 8e4da1bc.
